// File: rtl/ft245_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : ft245_fifo_if
// Brief    : FT245 asynchronous FIFO bus bridge with an RX byte FIFO and a
//            single-byte TX holding register.
// Revision : 1.0 - initial release
// ============================================================================
module ft245_fifo_if #(
  parameter int RX_DEPTH  = 8,
  parameter int RD_CYC    = 3,
  parameter int WR_CYC    = 2,
  parameter int RECOV_CYC = 3
) (
  input  logic                        CLK,
  input  logic                        rst_sync,
  input  logic                        nRXF,
  input  logic                        nTXE,
  inout  wire  [7:0]                  D,
  output logic                        nRD,
  output logic                        WR,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [$clog2(RX_DEPTH):0]   rx_level
);

  localparam int               c_AW         = $clog2(RX_DEPTH);
  localparam logic [c_AW:0]    c_DEPTH      = (c_AW + 1)'(RX_DEPTH);
  localparam logic [3:0]       c_RD_LAST    = 4'(RD_CYC - 1);
  localparam logic [3:0]       c_WR_LAST    = 4'(WR_CYC - 1);
  localparam logic [3:0]       c_RECOV_LAST = 4'(RECOV_CYC - 1);

  generate
    if (RX_DEPTH < 2 || RX_DEPTH > 64 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_rx_depth
      $error("ft245_fifo_if: RX_DEPTH must be a power of two in 2..64");
    end
    if (RD_CYC < 2 || RD_CYC > 15) begin : g_bad_rd_cyc
      $error("ft245_fifo_if: RD_CYC must be in 2..15");
    end
    if (WR_CYC < 1 || WR_CYC > 15) begin : g_bad_wr_cyc
      $error("ft245_fifo_if: WR_CYC must be in 1..15");
    end
    if (RECOV_CYC < 3 || RECOV_CYC > 15) begin : g_bad_recov_cyc
      $error("ft245_fifo_if: RECOV_CYC must be in 3..15");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_LOW   = 3'd1,
    WR_SETUP = 3'd2,
    WR_HIGH  = 3'd3,
    WR_HOLD  = 3'd4,
    RECOVER  = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic              r_rxf_meta, r_rxf_sync;
  logic              r_txe_meta, r_txe_sync;
  logic              r_nrd, r_wr, r_d_oe;
  logic [7:0]        r_tx_byte;
  logic              r_tx_full;
  logic [7:0]        r_mem [RX_DEPTH];
  logic [c_AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [c_AW:0]     r_level;
  logic              w_push, w_pop, w_tx_done, w_full;

  // Both status flags idle high so a reset never looks like pending traffic
  always_ff @(posedge CLK or negedge rst_sync) begin
    if (!rst_sync) begin
      r_rxf_meta <= 1'b1;
      r_rxf_sync <= 1'b1;
      r_txe_meta <= 1'b1;
      r_txe_sync <= 1'b1;
    end else begin
      r_rxf_meta <= nRXF;
      r_rxf_sync <= r_rxf_meta;
      r_txe_meta <= nTXE;
      r_txe_sync <= r_txe_meta;
    end
  end

  always_ff @(posedge CLK or negedge rst_sync) begin
    if (!rst_sync) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? 4'd0 : 4'(r_cnt + 4'd1);
    end
  end

  always_comb begin
    w_next    = r_state;
    w_push    = 1'b0;
    w_tx_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_tx_full && !r_txe_sync)
          w_next = WR_SETUP;
        else if (!r_rxf_sync && !w_full)
          w_next = RD_LOW;
      end
      RD_LOW: begin
        if (r_cnt == c_RD_LAST) begin
          w_next = RECOVER;
          w_push = 1'b1;
        end
      end
      WR_SETUP: w_next = WR_HIGH;
      WR_HIGH:  if (r_cnt == c_WR_LAST) w_next = WR_HOLD;
      WR_HOLD: begin
        w_next    = RECOVER;
        w_tx_done = 1'b1;
      end
      RECOVER:  if (r_cnt == c_RECOV_LAST) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Strobes and bus enable are registered from the next state so pins never glitch
  always_ff @(posedge CLK or negedge rst_sync) begin
    if (!rst_sync) begin
      r_nrd  <= 1'b1;
      r_wr   <= 1'b0;
      r_d_oe <= 1'b0;
    end else begin
      r_nrd  <= (w_next != RD_LOW);
      r_wr   <= (w_next == WR_HIGH);
      r_d_oe <= (w_next == WR_SETUP) || (w_next == WR_HIGH) || (w_next == WR_HOLD);
    end
  end

  assign nRD = r_nrd;
  assign WR  = r_wr;
  assign D   = r_d_oe ? r_tx_byte : 8'hzz;

  always_ff @(posedge CLK or negedge rst_sync) begin
    if (!rst_sync) begin
      r_tx_full <= 1'b0;
      r_tx_byte <= 8'h00;
    end else if (w_tx_done) begin
      r_tx_full <= 1'b0;
    end else if (tx_valid && !r_tx_full) begin
      r_tx_full <= 1'b1;
      r_tx_byte <= tx_data;
    end
  end

  assign tx_ready = !r_tx_full;

  assign w_full = (r_level == c_DEPTH);
  assign w_pop  = rx_valid && rx_ready;

  always_ff @(posedge CLK or negedge rst_sync) begin
    if (!rst_sync) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= D;
  end

  assign rx_level = r_level;
  assign rx_valid = (r_level != '0);
  assign rx_data  = rx_valid ? r_mem[r_rd_ptr] : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_ft245_fifo_if.sv
`default_nettype none
// Testbench for ft245_fifo_if: FT245 bus model with byte-stream reference queues.
module tb_ft245_fifo_if;
  localparam int RX_DEPTH  = 8;
  localparam int RD_CYC    = 3;
  localparam int WR_CYC    = 2;
  localparam int RECOV_CYC = 3;

  logic       CLK = 1'b0;
  logic       rst_sync = 1'b0;
  logic       nTXE = 1'b1;
  logic       rx_ready = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire        nRXF;
  tri1 [7:0]  D;
  logic       nRD, WR, rx_valid, tx_ready;
  logic [7:0] rx_data;
  logic [3:0] rx_level;

  ft245_fifo_if #(.RX_DEPTH(RX_DEPTH), .RD_CYC(RD_CYC), .WR_CYC(WR_CYC), .RECOV_CYC(RECOV_CYC)) dut (
    .CLK(CLK), .rst_sync(rst_sync), .nRXF(nRXF), .nTXE(nTXE), .D(D), .nRD(nRD), .WR(WR),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_level(rx_level)
  );

  logic [7:0] ft_q[$];     // bytes the FT245 still has to deliver
  logic [7:0] exp_rx[$];   // bytes delivered over the bus, not yet consumed
  logic [7:0] tx_seen[$];  // bytes captured on WR falling edges
  logic [7:0] exp_tx[$];
  logic       ft_en = 1'b1, ft_drive = 1'b0;
  logic [7:0] ft_byte = 8'h00;
  int cyc = 0, rd_fall_cyc = 0, wr_rise_cyc = 0, wr_fall_cyc = 0, reads_done = 0;
  int vectors = 0, miscompares = 0;

  assign D    = ft_drive ? ft_byte : 8'hzz;
  assign nRXF = ~(ft_en && (ft_q.size() != 0));

  always #5 CLK = ~CLK;
  always @(negedge CLK) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge nRD) if (rst_sync) begin
    rd_fall_cyc = cyc;
    ft_byte     = (ft_q.size() != 0) ? ft_q[0] : 8'hEE;
    ft_drive    = 1'b1;
  end

  always @(posedge nRD) if (ft_drive) begin
    ft_drive = 1'b0;
    if (rst_sync) begin
      check("nrd_low_cycles", cyc - rd_fall_cyc, RD_CYC);
      if (ft_q.size() != 0) exp_rx.push_back(ft_q.pop_front());
      reads_done++;
    end
  end

  always @(posedge WR) wr_rise_cyc = cyc;

  always @(negedge WR) if (rst_sync) begin
    wr_fall_cyc = cyc;
    check("wr_high_cycles", cyc - wr_rise_cyc, WR_CYC);
    tx_seen.push_back(D);
  end

  always @(negedge CLK) if (rst_sync) begin
    vectors++;
    assert (!(!nRD && WR)) else begin
      miscompares++;
      $error("FAIL strobe_overlap observed nRD=%b WR=%b expected never both active", nRD, WR);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pop_one(input string tag);
    check({tag, "_valid"}, rx_valid, 1);
    check({tag, "_data"}, rx_data, (exp_rx.size() != 0) ? exp_rx[0] : 8'h00);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    if (exp_rx.size() != 0) void'(exp_rx.pop_front());
  endtask

  task automatic wait_reads(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && reads_done < target; i++) tick();
    check(tag, reads_done, target);
  endtask

  initial begin
    int base;
    logic hs, pop_pend;

    // Reset values
    #12;
    check("rst_nrd", nRD, 1);
    check("rst_wr", WR, 0);
    check("rst_d_released", D, 8'hFF);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_level", rx_level, 0);

    // Single read with nRXF already low at release: first strobe after three edges
    ft_q.push_back(8'hA5);
    tick(); tick();
    @(negedge CLK) rst_sync = 1'b1;
    tick(); check("startup_edge1_nrd", nRD, 1);
    tick(); check("startup_edge2_nrd", nRD, 1);
    tick(); check("startup_edge3_nrd", nRD, 0);
    wait_reads(1, 20, "single_read_done");
    check("single_rx_valid", rx_valid, 1);
    check("single_rx_data", rx_data, 8'hA5);
    check("single_rx_level", rx_level, 1);
    pop_one("single_pop");
    check("single_level_after_pop", rx_level, 0);

    // Fill the FIFO with rx_ready low, then drain and check order
    base = reads_done;
    for (int b = 1; b <= 10; b++) ft_q.push_back(8'(b));
    repeat (100) tick();
    check("full_reads", reads_done - base, 8);
    check("full_level", rx_level, RX_DEPTH);
    check("full_nrd_idle", nRD, 1);
    for (int b = 1; b <= 10; b++) begin
      for (int t = 0; t < 40 && exp_rx.size() == 0; t++) tick();
      check("full_order", rx_data, b);
      pop_one("full_pop");
    end
    check("full_drained_level", rx_level, 0);

    // Single write
    tx_data = 8'h3C; tx_valid = 1'b1; nTXE = 1'b0;
    check("wr_tx_ready_before", tx_ready, 1);
    tick();
    check("wr_tx_ready_loaded", tx_ready, 0);
    tx_valid = 1'b0;
    for (int t = 0; t < 10 && !WR; t++) begin
      if (D !== 8'hFF) check("wr_d_setup", D, 8'h3C);
      tick();
    end
    check("wr_started", WR, 1);
    for (int t = 0; t < 20 && WR; t++) begin
      check("wr_d_high", D, 8'h3C);
      tick();
    end
    check("wr_hold_d", D, 8'h3C);
    check("wr_hold_tx_ready", tx_ready, 0);
    tick();
    check("wr_done_tx_ready", tx_ready, 1);
    check("wr_done_d_released", D, 8'hFF);
    check("wr_capture_count", tx_seen.size(), 1);
    if (tx_seen.size() != 0) check("wr_capture_byte", tx_seen.pop_front(), 8'h3C);

    // Contention: TX pending and RX available become visible on the same edge
    nTXE = 1'b1;
    repeat (8) tick();
    tx_data = 8'h5A; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (5) tick();
    check("cont_wr_waits_txe", WR, 0);
    base = reads_done;
    ft_q.push_back(8'h77); nTXE = 1'b0;
    wait_reads(base + 1, 40, "cont_read_done");
    check("cont_write_first", (wr_rise_cyc < rd_fall_cyc), 1);
    check("cont_recover_gap", rd_fall_cyc - wr_fall_cyc, RECOV_CYC + 2);
    check("cont_tx_count", tx_seen.size(), 1);
    if (tx_seen.size() != 0) check("cont_tx_byte", tx_seen.pop_front(), 8'h5A);
    pop_one("cont_pop");

    // Push and pop on the same edge with four bytes already held
    base = reads_done;
    for (int i = 0; i < 4; i++) ft_q.push_back(8'h40 + 8'(i));
    ft_q.push_back(8'h50);
    wait_reads(base + 4, 80, "cc_fill_reads");
    check("cc_level_4", rx_level, 4);
    for (int t = 0; t < 20 && nRD; t++) tick();
    check("cc_read_started", nRD, 0);
    repeat (RD_CYC - 1) tick();
    check("cc_last_low_cycle", nRD, 0);
    check("cc_level_before", rx_level, 4);
    check("cc_head", rx_data, 8'h40);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    void'(exp_rx.pop_front());
    check("cc_push_done", reads_done, base + 5);
    check("cc_level_same", rx_level, 4);
    check("cc_model_level", rx_level, exp_rx.size());
    check("cc_next0", rx_data, 8'h41); pop_one("cc_pop");
    check("cc_next1", rx_data, 8'h42); pop_one("cc_pop");
    check("cc_next2", rx_data, 8'h43); pop_one("cc_pop");
    check("cc_next3", rx_data, 8'h50); pop_one("cc_pop");
    check("cc_empty", rx_valid, 0);

    // Reset during WR_HIGH
    tx_data = 8'hC3; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int t = 0; t < 10 && !WR; t++) tick();
    check("rw_wr_high", WR, 1);
    #2 rst_sync = 1'b0;
    #1;
    check("rw_wr_low", WR, 0);
    check("rw_d_released", D, 8'hFF);
    check("rw_tx_ready", tx_ready, 1);
    check("rw_nrd", nRD, 1);
    tick(); tick();
    tx_data = 8'h6E; tx_valid = 1'b1;
    @(negedge CLK) rst_sync = 1'b1;
    tick(); tx_valid = 1'b0;
    check("rw_edge1_wr", WR, 0); check("rw_edge1_d", D, 8'hFF);
    tick(); check("rw_edge2_wr", WR, 0); check("rw_edge2_d", D, 8'hFF);
    tick(); check("rw_edge3_wr", WR, 0);
    check("rw_aborted_not_sent", tx_seen.size(), 0);
    for (int t = 0; t < 20 && tx_seen.size() == 0; t++) tick();
    check("rw_next_write_count", tx_seen.size(), 1);
    if (tx_seen.size() != 0) check("rw_next_write_byte", tx_seen.pop_front(), 8'h6E);
    repeat (6) tick();

    // Randomized traffic against the byte-stream model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0 && ft_q.size() < 4) ft_q.push_back(8'($urandom));
      ft_en = ($urandom_range(0, 3) != 0);
      nTXE  = ($urandom_range(0, 3) == 0);
      if (!tx_valid && $urandom_range(0, 5) == 0) begin
        tx_valid = 1'b1;
        tx_data  = 8'($urandom);
      end
      check("rnd_rx_valid", rx_valid, exp_rx.size() != 0);
      check("rnd_rx_level", rx_level, exp_rx.size());
      if (exp_rx.size() != 0) check("rnd_rx_data", rx_data, exp_rx[0]);
      rx_ready = ($urandom_range(0, 2) == 0);
      pop_pend = rx_ready && (exp_rx.size() != 0);
      hs = tx_valid && tx_ready;
      if (hs) exp_tx.push_back(tx_data);
      tick();
      if (hs) tx_valid = 1'b0;
      if (pop_pend) void'(exp_rx.pop_front());
    end

    // Flush everything still in flight
    ft_en = 1'b1; nTXE = 1'b0; rx_ready = 1'b1;
    for (int t = 0; t < 400 && (ft_q.size() != 0 || exp_rx.size() != 0 || ft_drive || !tx_ready); t++) begin
      if (exp_rx.size() != 0) check("flush_rx_data", rx_data, exp_rx[0]);
      pop_pend = exp_rx.size() != 0;
      tick();
      if (pop_pend) void'(exp_rx.pop_front());
    end
    rx_ready = 1'b0;
    repeat (10) tick();
    check("flush_ft_empty", ft_q.size(), 0);
    check("flush_rx_level", rx_level, exp_rx.size());
    check("rnd_tx_count", tx_seen.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_seen.size(); i++)
      check("rnd_tx_byte", tx_seen[i], exp_tx[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
